// File: rtl/ucsbece154_dmem_ctrl_if.sv
// Lane request/response and dual-port data-memory signals of the MEM-stage
// memory controller; suffixes are as seen from the controller.
interface ucsbece154_dmem_ctrl_if;
   logic        l0_valid_i, l1_valid_i;
   logic        l0_we_i,    l1_we_i;
   logic [31:0] l0_a_i,     l1_a_i;
   logic [31:0] l0_wd_i,    l1_wd_i;
   logic [31:0] l0_rd_o,    l1_rd_o;
   logic        l0_ack_o,   l1_ack_o;
   logic        mem_we1_o,  mem_we2_o;
   logic [31:0] mem_a1_o,   mem_a2_o;
   logic [31:0] mem_wd1_o,  mem_wd2_o;
   logic [31:0] mem_rd1_i,  mem_rd2_i;
   logic        sb_empty_o;

   modport slave (
      input  l0_valid_i, l1_valid_i, l0_we_i, l1_we_i,
      input  l0_a_i, l1_a_i, l0_wd_i, l1_wd_i,
      output l0_rd_o, l1_rd_o, l0_ack_o, l1_ack_o,
      output mem_we1_o, mem_we2_o, mem_a1_o, mem_a2_o, mem_wd1_o, mem_wd2_o,
      input  mem_rd1_i, mem_rd2_i,
      output sb_empty_o
   );

   modport master (
      output l0_valid_i, l1_valid_i, l0_we_i, l1_we_i,
      output l0_a_i, l1_a_i, l0_wd_i, l1_wd_i,
      input  l0_rd_o, l1_rd_o, l0_ack_o, l1_ack_o,
      input  mem_we1_o, mem_we2_o, mem_a1_o, mem_a2_o, mem_wd1_o, mem_wd2_o,
      output mem_rd1_i, mem_rd2_i,
      input  sb_empty_o
   );
endinterface

// File: rtl/ucsbece154_dmem_ctrl.sv
// Dual-lane memory-port scheduler with an in-order store buffer drained on
// load-idle ports. Define STORE_FWD_EN to forward buffered data to loads.
module ucsbece154_dmem_ctrl #(
   parameter int SB_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   ucsbece154_dmem_ctrl_if.slave bus
);
   localparam int PW = $clog2(SB_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] ONE_C  = CW'(1);
   localparam logic [CW-1:0] TWO_C  = CW'(2);
   localparam logic [CW-1:0] ZERO_C = CW'(0);

   logic [29:0]   waddr_q [SB_DEPTH];
   logic [31:0]   wdata_q [SB_DEPTH];
   logic [PW-1:0] head_q, head_d, tail_q, tail_d;
   logic [CW-1:0] count_q, count_d, free_s;

   logic [29:0]   wa0_s, wa1_s;
   logic          st0_s, st1_s, ld0_s, ld1_s;
   logic          hit0_s, hit1_s, same01_s;
   logic          ack0_s, ack1_s;
   logic          p1_free_s, p2_free_s;
   logic          drain_a_s, drain_b_s;
   logic          enq0_s, enq1_s;
   logic [1:0]    deq_s;
   logic [PW-1:0] head1_s, tail1_s;
`ifdef STORE_FWD_EN
   logic [31:0]   fwd0_s, fwd1_s;
`endif

   assign wa0_s    = bus.l0_a_i[31:2];
   assign wa1_s    = bus.l1_a_i[31:2];
   assign st0_s    = bus.l0_valid_i & bus.l0_we_i;
   assign st1_s    = bus.l1_valid_i & bus.l1_we_i;
   assign ld0_s    = bus.l0_valid_i & ~bus.l0_we_i;
   assign ld1_s    = bus.l1_valid_i & ~bus.l1_we_i;
   assign same01_s = st0_s & (wa0_s == wa1_s);
   assign free_s   = CW'(SB_DEPTH) - count_q;

   // Scan oldest to youngest so the last hit is the youngest buffered store.
   always_comb begin
      logic [PW-1:0] idx;
      logic          h0, h1;
      idx    = {PW{1'b0}};
      h0     = 1'b0;
      h1     = 1'b0;
      hit0_s = 1'b0;
      hit1_s = 1'b0;
`ifdef STORE_FWD_EN
      fwd0_s = 32'd0;
      fwd1_s = 32'd0;
`endif
      for (int i = 0; i < SB_DEPTH; i++) begin
         idx    = head_q + PW'(i);
         h0     = (CW'(i) < count_q) && (waddr_q[idx] == wa0_s);
         h1     = (CW'(i) < count_q) && (waddr_q[idx] == wa1_s);
         hit0_s = hit0_s | h0;
         hit1_s = hit1_s | h1;
`ifdef STORE_FWD_EN
         fwd0_s = h0 ? wdata_q[idx] : fwd0_s;
         fwd1_s = h1 ? wdata_q[idx] : fwd1_s;
`endif
      end
   end

   // Lane acceptance: capacity for stores, address hazards for loads.
   always_comb begin
      ack0_s = 1'b0;
      ack1_s = 1'b0;
      if (reset) begin
         ack0_s = 1'b0;
         ack1_s = 1'b0;
      end else begin
`ifdef STORE_FWD_EN
         ack0_s = st0_s ? (free_s >= ONE_C) : ld0_s;
         ack1_s = ack0_s & (st1_s ? (free_s >= (st0_s ? TWO_C : ONE_C)) : ld1_s);
`else
         ack0_s = st0_s ? (free_s >= ONE_C) : (ld0_s & ~hit0_s);
         ack1_s = ack0_s & (st1_s ? (free_s >= (st0_s ? TWO_C : ONE_C))
                                  : (ld1_s & ~hit1_s & ~same01_s));
`endif
      end
   end

   assign p1_free_s = ~(ack0_s & ld0_s);
   assign p2_free_s = ~(ack1_s & ld1_s);
   assign head1_s   = head_q + PW'(1);
   assign drain_a_s = ~reset & (count_q != ZERO_C) & (p1_free_s | p2_free_s);
   // Same-word neighbours never share a cycle, keeping write order unambiguous.
   assign drain_b_s = ~reset & (count_q >= TWO_C) & p1_free_s & p2_free_s &
                      (waddr_q[head1_s] != waddr_q[head_q]);

   // Memory port muxing: loads first, then head / head+1 drains, else idle.
   always_comb begin
      bus.mem_we1_o = 1'b0;
      bus.mem_a1_o  = 32'd0;
      bus.mem_wd1_o = 32'd0;
      bus.mem_we2_o = 1'b0;
      bus.mem_a2_o  = 32'd0;
      bus.mem_wd2_o = 32'd0;
      if (!p1_free_s) begin
         bus.mem_a1_o  = bus.l0_a_i;
      end else if (drain_a_s) begin
         bus.mem_we1_o = 1'b1;
         bus.mem_a1_o  = {waddr_q[head_q], 2'b00};
         bus.mem_wd1_o = wdata_q[head_q];
      end else begin
         bus.mem_we1_o = 1'b0;
      end
      if (!p2_free_s) begin
         bus.mem_a2_o  = bus.l1_a_i;
      end else if (drain_a_s && !p1_free_s) begin
         bus.mem_we2_o = 1'b1;
         bus.mem_a2_o  = {waddr_q[head_q], 2'b00};
         bus.mem_wd2_o = wdata_q[head_q];
      end else if (drain_b_s) begin
         bus.mem_we2_o = 1'b1;
         bus.mem_a2_o  = {waddr_q[head1_s], 2'b00};
         bus.mem_wd2_o = wdata_q[head1_s];
      end else begin
         bus.mem_we2_o = 1'b0;
      end
   end

`ifdef STORE_FWD_EN
   assign bus.l0_rd_o = p1_free_s ? 32'd0 : (hit0_s ? fwd0_s : bus.mem_rd1_i);
   assign bus.l1_rd_o = p2_free_s ? 32'd0 :
                        (same01_s ? bus.l0_wd_i : (hit1_s ? fwd1_s : bus.mem_rd2_i));
`else
   assign bus.l0_rd_o = p1_free_s ? 32'd0 : bus.mem_rd1_i;
   assign bus.l1_rd_o = p2_free_s ? 32'd0 : bus.mem_rd2_i;
`endif
   assign bus.l0_ack_o   = ack0_s;
   assign bus.l1_ack_o   = ack1_s;
   assign bus.sb_empty_o = reset | (count_q == ZERO_C);

   assign enq0_s  = ack0_s & st0_s;
   assign enq1_s  = ack1_s & st1_s;
   assign deq_s   = {1'b0, drain_a_s} + {1'b0, drain_b_s};
   assign tail1_s = enq0_s ? (tail_q + PW'(1)) : tail_q;
   assign tail_d  = tail_q + PW'(enq0_s) + PW'(enq1_s);
   assign head_d  = head_q + PW'(deq_s);
   assign count_d = count_q + CW'(enq0_s) + CW'(enq1_s) - CW'(deq_s);

   // Buffer pointers and occupancy.
   always_ff @(posedge clk) begin
      if (reset) begin
         head_q  <= {PW{1'b0}};
         tail_q  <= {PW{1'b0}};
         count_q <= ZERO_C;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Entry storage, written in lane order.
   always_ff @(posedge clk) begin
      if (enq0_s) begin
         waddr_q[tail_q]  <= wa0_s;
         wdata_q[tail_q]  <= bus.l0_wd_i;
      end
      if (enq1_s) begin
         waddr_q[tail1_s] <= wa1_s;
         wdata_q[tail1_s] <= bus.l1_wd_i;
      end
   end
endmodule
